weight_mem_loader: RTL and testbench



---
 rtl/weight_mem_loader.sv | 128 ++++++++++++
 tb/tb_weight_mem_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_mem_loader.sv
// Packs IN_WIDTH-bit stream beats (first beat in the MSBs) into WORD_W-bit kernel words
// and writes them to consecutive BRAM port-A addresses from a commanded base, then pulses done.
module weight_mem_loader #(
  parameter int KERNEL_SIZE  = 5,
  parameter int KERNEL_WIDTH = 2,
  parameter int IN_WIDTH     = 10,
  parameter int ADDR_W       = 9,
  localparam int WORD_W      = KERNEL_SIZE * KERNEL_SIZE * KERNEL_WIDTH,
  localparam int BEATS       = WORD_W / IN_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [9:0]          base_addr,
  input  logic [9:0]          word_count,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_WIDTH-1:0] s_data,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_din,
  output logic                busy,
  output logic                done
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, LAST, FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [9:0]          count_q, count_d;
  logic [9:0]          word_q, word_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_din_q, mem_din_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [WORD_W-1:0]   packed_word;
  logic                accept;
  logic                unused_base;

  assign unused_base = ^base_addr;
  assign s_ready     = (state_q == LOAD);
  assign accept      = s_valid && s_ready;
  assign packed_word = {shift_q[WORD_W-IN_WIDTH-1:0], s_data};

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    word_d     = word_q;
    beat_d     = beat_q;
    shift_d    = shift_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr[ADDR_W-1:0];
          count_d = word_count;
          beat_d  = '0;
          word_d  = '0;
          state_d = (word_count == 10'd0) ? FIN : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          shift_d = packed_word;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            // Address and data are latched separately so the shifter can take the next word's beat immediately.
            beat_d     = '0;
            word_d     = word_q + 10'd1;
            mem_we_d   = 1'b1;
            mem_din_d  = packed_word;
            mem_addr_d = base_q + word_q[ADDR_W-1:0];
            if (word_q == count_q - 10'd1) state_d = LAST;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      LAST:    state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      word_q     <= '0;
      beat_q     <= '0;
      shift_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      word_q     <= word_d;
      beat_q     <= beat_d;
      shift_q    <= shift_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_weight_mem_loader.sv
// Randomized bench for weight_mem_loader: expected writes come from a word-level model of the beat stream.
module tb_weight_mem_loader;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_ready, mem_we, busy, done;
  logic [9:0]  base_addr, word_count, s_data;
  logic [8:0]  mem_addr;
  logic [49:0] mem_din;

  weight_mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [9:0]  beats_q[$];
  logic [8:0]  exp_addr[$];
  logic [49:0] exp_din[$];
  logic [8:0]  wr_addr[$];
  logic [49:0] wr_din[$];
  int          wr_cyc[$];
  int          done_cyc[$];
  int          ready_cnt;
  int          start_edge;
  int          last_acc_edge;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_din.push_back(mem_din);
      wr_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (s_ready) ready_cnt++;
  end

  task automatic clear_mon();
    wr_addr.delete(); wr_din.delete(); wr_cyc.delete(); done_cyc.delete();
    ready_cnt = 0;
  endtask

  task automatic gen_beats(input int n);
    beats_q.delete();
    for (int i = 0; i < n; i++) beats_q.push_back(10'($urandom));
  endtask

  // Word i is beats 5i..5i+4 weighted MSB-first; address is base+i modulo 512.
  task automatic build_exp(input int base, input int count);
    exp_addr.delete(); exp_din.delete();
    for (int i = 0; i < count; i++) begin
      logic [49:0] w;
      w = '0;
      for (int j = 0; j < 5; j++) w = w + (50'(beats_q[5*i+j]) << (10 * (4 - j)));
      exp_din.push_back(w);
      exp_addr.push_back(9'((base + i) % 512));
    end
  endtask

  task automatic kick(input logic [9:0] b, input logic [9:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    @(posedge clk); #1;
    start = 1'b0;
    start_edge = cyc;
  endtask

  task automatic drive_beats(input int n, input int bubble_pct);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 5000) begin
      s_valid = ($urandom_range(99) >= bubble_pct);
      s_data  = s_valid ? beats_q[idx] : 10'($urandom);
      @(negedge clk);
      if (s_valid && s_ready) begin
        idx++;
        last_acc_edge = cyc + 1;
      end
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0;
    s_data  = 10'($urandom);
    checks++;
    if (idx !== n) begin
      errors++;
      $display("FAIL drive_timeout accepted=%0d required=%0d", idx, n);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout busy=%b required=0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; base_addr = 10'h055; word_count = 10'd3;
    s_valid = 1'b1; s_data = 10'h3FF;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; start = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b0)   begin errors++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 9'h0)  begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_din !== 50'h0)  begin errors++; $display("FAIL reset_mem_din got=%h exp=0", mem_din); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [49:0] ref_word;
    clear_mon();
    beats_q = '{10'h3FF, 10'h000, 10'h155, 10'h2AA, 10'h001};
    ref_word = {10'h3FF, 10'h000, 10'h155, 10'h2AA, 10'h001};
    kick(10'h010, 10'd1);
    drive_beats(5, 0);
    wait_idle();
    checks++; if (wr_addr.size() !== 1) begin errors++; $display("FAIL single_nwrites got=%0d exp=1", wr_addr.size()); end
    else begin
      checks++; if (wr_addr[0] !== 9'h010) begin errors++; $display("FAIL single_addr got=%h exp=010", wr_addr[0]); end
      checks++; if (wr_din[0] !== ref_word) begin errors++; $display("FAIL single_din got=%h exp=%h", wr_din[0], ref_word); end
      checks++; if (wr_cyc[0] !== last_acc_edge) begin errors++; $display("FAIL single_we_latency got=%0d exp=%0d", wr_cyc[0], last_acc_edge); end
    end
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== last_acc_edge + 1) begin
      errors++; $display("FAIL single_done n=%0d at=%0d exp_at=%0d", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, last_acc_edge + 1);
    end
    checks++; if (mem_addr !== 9'h010 || mem_din !== ref_word) begin
      errors++; $display("FAIL single_hold addr=%h din=%h exp_addr=010 exp_din=%h", mem_addr, mem_din, ref_word);
    end
  endtask

  task automatic test_stream();
    clear_mon();
    gen_beats(160);
    build_exp(0, 32);
    kick(10'h000, 10'd32);
    drive_beats(160, 0);
    wait_idle();
    checks++; if (wr_addr.size() !== 32) begin errors++; $display("FAIL stream_nwrites got=%0d exp=32", wr_addr.size()); end
    else begin
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (wr_addr[i] !== exp_addr[i] || wr_din[i] !== exp_din[i]) begin
          errors++; $display("FAIL stream_word%0d got=%h/%h exp=%h/%h", i, wr_addr[i], wr_din[i], exp_addr[i], exp_din[i]);
        end
        if (i > 0) begin
          checks++;
          if (wr_cyc[i] - wr_cyc[i-1] !== 5) begin
            errors++; $display("FAIL stream_spacing%0d got=%0d exp=5", i, wr_cyc[i] - wr_cyc[i-1]);
          end
        end
      end
    end
    checks++; if (ready_cnt !== 160) begin errors++; $display("FAIL stream_ready_cycles got=%0d exp=160", ready_cnt); end
    checks++; if (done_cyc.size() !== 1) begin errors++; $display("FAIL stream_done_count got=%0d exp=1", done_cyc.size()); end
  endtask

  task automatic test_bubbles();
    for (int rep = 0; rep < 3; rep++) begin
      clear_mon();
      gen_beats(10);
      build_exp(10'h123, 2);
      kick(10'h123, 10'd2);
      drive_beats(10, 50);
      wait_idle();
      checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL bubbles_nwrites rep%0d got=%0d exp=2", rep, wr_addr.size()); end
      else begin
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (wr_addr[i] !== exp_addr[i] || wr_din[i] !== exp_din[i]) begin
            errors++; $display("FAIL bubbles_word%0d rep%0d got=%h/%h exp=%h/%h", i, rep, wr_addr[i], wr_din[i], exp_addr[i], exp_din[i]);
          end
        end
      end
      checks++; if (done_cyc.size() !== 1) begin errors++; $display("FAIL bubbles_done rep%0d got=%0d exp=1", rep, done_cyc.size()); end
    end
  endtask

  task automatic test_wrap();
    clear_mon();
    gen_beats(20);
    build_exp(10'h1FE, 4);
    kick(10'h1FE, 10'd4);
    drive_beats(20, 20);
    wait_idle();
    checks++; if (wr_addr.size() !== 4) begin errors++; $display("FAIL wrap_nwrites got=%0d exp=4", wr_addr.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr[i] !== exp_addr[i] || wr_din[i] !== exp_din[i]) begin
          errors++; $display("FAIL wrap_word%0d got=%h/%h exp=%h/%h", i, wr_addr[i], wr_din[i], exp_addr[i], exp_din[i]);
        end
      end
    end
  endtask

  task automatic test_zero_count();
    clear_mon();
    kick(10'h0AA, 10'd0);
    wait_idle();
    checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL zero_writes got=%0d exp=0", wr_addr.size()); end
    checks++; if (ready_cnt !== 0) begin errors++; $display("FAIL zero_ready got=%0d exp=0", ready_cnt); end
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== start_edge) begin
      errors++; $display("FAIL zero_done n=%0d at=%0d exp_at=%0d", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, start_edge);
    end
  endtask

  task automatic test_start_ignored();
    clear_mon();
    gen_beats(15);
    build_exp(10'h080, 3);
    kick(10'h080, 10'd3);
    fork
      drive_beats(15, 30);
      begin
        repeat (4) @(posedge clk);
        #1; start = 1'b1; base_addr = 10'h1F0; word_count = 10'd7;
        @(posedge clk); #1; start = 1'b0;
      end
    join
    wait_idle();
    checks++; if (wr_addr.size() !== 3) begin errors++; $display("FAIL busy_start_nwrites got=%0d exp=3", wr_addr.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr[i] !== exp_addr[i] || wr_din[i] !== exp_din[i]) begin
          errors++; $display("FAIL busy_start_word%0d got=%h/%h exp=%h/%h", i, wr_addr[i], wr_din[i], exp_addr[i], exp_din[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    gen_beats(5);
    kick(10'h040, 10'd1);
    drive_beats(3, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL rstmid_writes got=%0d exp=0", wr_addr.size()); end
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL rstmid_idle busy=%b s_ready=%b exp=0/0", busy, s_ready); end
    gen_beats(5);
    build_exp(10'h041, 1);
    kick(10'h041, 10'd1);
    drive_beats(5, 0);
    wait_idle();
    checks++; if (wr_addr.size() !== 1) begin errors++; $display("FAIL rstmid_fresh_nwrites got=%0d exp=1", wr_addr.size()); end
    else begin
      checks++;
      if (wr_addr[0] !== exp_addr[0] || wr_din[0] !== exp_din[0]) begin
        errors++; $display("FAIL rstmid_fresh_word got=%h/%h exp=%h/%h", wr_addr[0], wr_din[0], exp_addr[0], exp_din[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; s_valid = 1'b0; s_data = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_stream();
    test_bubbles();
    test_wrap();
    test_zero_count();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
